// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB completer among NUM_REQ valid/ready requesters.
// Optional ACCESS-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_STRB  = DATA_WIDTH/8,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_STRB-1:0]    req_strb,
    input  logic [NUM_REQ*3-1:0]            req_prot,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            psel,
    output logic                            penable,
    output logic                            pwrite,
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic [DATA_WIDTH-1:0]           pwdata,
    output logic [DATA_STRB-1:0]            pstrb,
    output logic [2:0]                      prot,
    input  logic                            pready,
    input  logic                            slverr,
    input  logic [DATA_WIDTH-1:0]           prdata
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("apb_arbiter: unsupported parameter set");
    end

    logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];
    logic [DATA_STRB-1:0]  w_strb  [NUM_REQ];
    logic [2:0]            w_prot  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign w_strb[g]  = req_strb[g*DATA_STRB +: DATA_STRB];
        assign w_prot[g]  = req_prot[g*3 +: 3];
    end

    logic [1:0]            r_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      r_grant;
    logic                  r_psel, r_penable, r_pwrite, r_rsp_err;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata, r_rsp_rdata;
    logic [DATA_STRB-1:0]  r_pstrb;
    logic [2:0]            r_prot;
    logic [NUM_REQ-1:0]    r_req_ready, r_rsp_valid;

    logic                  w_any;
    logic [PTR_W-1:0]      w_win;
    logic                  w_timeout;
    logic                  w_done;

    // First valid requester at or above rr_ptr, searching upward with wrap.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int j;
            j = int'(r_rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_any && req_valid[j]) begin
                w_any = 1'b1;
                w_win = PTR_W'(j);
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    // A pready on the limit cycle wins over the timeout.
    assign w_timeout = (r_state == S_ACCESS) && !pready && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                                 r_to_cnt <= '0;
        else if (r_state != S_ACCESS || pready)    r_to_cnt <= '0;
        else                                       r_to_cnt <= r_to_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = (r_state == S_ACCESS) && (pready || w_timeout);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_prot      <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_state     <= S_SETUP;
                    r_grant     <= w_win;
                    r_psel      <= 1'b1;
                    r_penable   <= 1'b0;
                    r_pwrite    <= req_write[w_win];
                    r_paddr     <= w_addr[w_win];
                    r_pwdata    <= req_write[w_win] ? w_wdata[w_win] : '0;
                    r_pstrb     <= req_write[w_win] ? w_strb[w_win]  : '0;
                    r_prot      <= w_prot[w_win];
                    r_req_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: if (w_done) begin
                    r_state     <= S_IDLE;
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
                    r_rsp_rdata <= (pready && !r_pwrite) ? prdata : '0;
                    r_rsp_err   <= pready ? slverr : 1'b1;
                    r_rr_ptr    <= (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign prot      = r_prot;
endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: vector table of single transfers plus hand sequences
// for round-robin order, mid-transfer reset and (with APB_ARB_TIMEOUT_EN) the watchdog.
module tb_apb_arbiter;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [N-1:0]  req_valid = '0, req_write = '0;
    logic [N*32-1:0] req_addr = '0, req_wdata = '0;
    logic [N*4-1:0]  req_strb = '0;
    logic [N*3-1:0]  req_prot = '0;
    logic [N-1:0]  req_ready, rsp_valid;
    logic [31:0]   rsp_rdata, paddr, pwdata, prdata;
    logic          rsp_err, psel, penable, pwrite, pready, slverr;
    logic [3:0]    pstrb;
    logic [2:0]    prot;

    apb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_STRB(4), .TIMEOUT(16)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prot(prot), .pready(pready), .slverr(slverr), .prdata(prdata));

    always #5 clk = ~clk;

    // Simple completer: cur_wait ACCESS wait states, then pready with slverr=cur_err.
    int          cur_wait = 0;
    logic        cur_err = 1'b0;
    int          acc_cnt = 0;
    logic [31:0] mem [16];

    assign pready = psel && penable && (acc_cnt >= cur_wait);
    assign slverr = cur_err;
    assign prdata = mem[paddr[3:0]];

    always @(posedge clk) begin
        if (!(psel && penable) || pready) acc_cnt <= 0;
        else                              acc_cnt <= acc_cnt + 1;
        if (psel && penable && pready && pwrite) mem[paddr[3:0]] <= pwdata;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt[5];

    task automatic drive_req(input int id, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        req_valid[id]          = 1'b1;
        req_write[id]          = wr;
        req_addr[id*32 +: 32]  = a;
        req_wdata[id*32 +: 32] = d;
        req_strb[id*4 +: 4]    = s;
        req_prot[id*3 +: 3]    = p;
    endtask

    // Called one time unit after an edge with the arbiter in IDLE (cycle 0).
    task automatic run_vec(input vec_t v);
        logic [N-1:0] oh;
        logic [31:0]  exp_wd;
        logic [3:0]   exp_st;
        int           cyc;
        bit           got;
        oh     = '0;
        oh[v.id] = 1'b1;
        exp_wd = v.wr ? v.wdata : 32'h0;
        exp_st = v.wr ? v.strb  : 4'h0;
        cur_wait = v.waits;
        cur_err  = v.err;
        chk("idle_psel", {63'd0, psel}, 64'd0);
        drive_req(v.id, v.wr, v.addr, v.wdata, v.strb, v.prot);
        tick();
        chk("setup_ctl", {61'd0, psel, penable, pwrite}, {61'd0, 1'b1, 1'b0, v.wr});
        chk("setup_ready", {62'd0, req_ready}, {62'd0, oh});
        chk("setup_addr", {32'd0, paddr}, {32'd0, v.addr});
        chk("setup_wdata_strb", {28'd0, pwdata, pstrb}, {28'd0, exp_wd, exp_st});
        chk("setup_prot", {61'd0, prot}, {61'd0, v.prot});
        req_valid[v.id] = 1'b0;
        got = 0;
        for (cyc = 2; cyc < 40; cyc++) begin
            tick();
            if (rsp_valid != '0) begin got = 1; break; end
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== v.addr || pwdata !== exp_wd ||
                pstrb !== exp_st || req_ready !== '0) begin
                chk("access_stable", {28'd0, psel, penable, paddr, pstrb, 2'd0}, {28'd0, 1'b1, 1'b1, v.addr, exp_st, 2'd0});
            end
        end
        chk("rsp_seen", {63'd0, got}, 64'd1);
        chk("rsp_latency", 64'(cyc), 64'(3 + v.waits));
        chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, oh});
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, v.exp_err});
        chk("rsp_psel_low", {62'd0, psel, penable}, 64'd0);
    endtask

    initial begin
        int gr[4];
        int gc[4];
        int ng;
        bit got;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;

        //          id wr   addr   wdata          strb     prot  w  err  exp_rdata      exp_err
        vt[0] = '{0, 1'b1, 32'd3, 32'h12345678, 4'b1111, 3'd2, 0, 1'b0, 32'h0,        1'b0};
        vt[1] = '{1, 1'b0, 32'd3, 32'hDEADBEEF, 4'b1111, 3'd0, 0, 1'b0, 32'h12345678, 1'b0};
        vt[2] = '{1, 1'b0, 32'd3, 32'h0,        4'b0000, 3'd5, 3, 1'b1, 32'h12345678, 1'b1};
        vt[3] = '{0, 1'b1, 32'd7, 32'hA5A5A5A5, 4'b0101, 3'd1, 1, 1'b0, 32'h0,        1'b0};
        vt[4] = '{0, 1'b0, 32'd7, 32'h0,        4'b1111, 3'd7, 0, 1'b0, 32'hA5A5A5A5, 1'b0};

        // Reset values
        #12;
        chk("rst_ctl", {59'd0, psel, penable, pwrite, rsp_err, 1'b0}, 64'd0);
        chk("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
        chk("rst_strb_prot", {57'd0, pstrb, prot}, 64'd0);
        chk("rst_ready_valid", {60'd0, req_ready, rsp_valid}, 64'd0);
        chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        @(posedge clk); #1 nrst = 1'b1;

        // Round robin from reset: both valid continuously, 4 grants
        cur_wait = 0; cur_err = 1'b0;
        drive_req(0, 1'b1, 32'd1, 32'h11, 4'hF, 3'd0);
        drive_req(1, 1'b1, 32'd2, 32'h22, 4'hF, 3'd0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (req_ready != '0) begin
                gr[ng] = (req_ready == 2'b10) ? 1 : (req_ready == 2'b01) ? 0 : 9;
                gc[ng] = c;
                ng++;
            end
        end
        req_valid = '0;
        chk("rr_count", 64'(ng), 64'd4);
        chk("rr_order", {32'd0, 8'(gr[0]), 8'(gr[1]), 8'(gr[2]), 8'(gr[3])}, {32'd0, 8'd0, 8'd1, 8'd0, 8'd1});
        chk("rr_period", {32'd0, 16'(gc[1] - gc[0]), 16'(gc[3] - gc[2])}, {32'd0, 16'd3, 16'd3});
        got = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid != '0) begin got = 1; break; end
        end
        chk("rr_last_rsp", {62'd0, got, rsp_valid[1]}, {62'd0, 1'b1, 1'b1});
        tick();

        // Table-driven single transfers
        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Reset in ACCESS: rr_ptr is 1 here, so a non-reset pointer would grant requester 1
        cur_wait = 20; cur_err = 1'b0;
        drive_req(1, 1'b0, 32'd4, 32'h0, 4'h0, 3'd0);
        tick();
        chk("rstx_ready", {62'd0, req_ready}, 64'd2);
        req_valid = '0;
        tick(); tick();
        chk("rstx_access", {62'd0, psel, penable}, 64'd3);
        nrst = 1'b0;
        #1;
        chk("rstx_drop", {62'd0, psel, penable}, 64'd0);
        tick();
        chk("rstx_norsp", {62'd0, rsp_valid}, 64'd0);
        nrst = 1'b1;
        cur_wait = 0;
        drive_req(0, 1'b0, 32'd3, 32'h0, 4'h0, 3'd0);
        drive_req(1, 1'b0, 32'd7, 32'h0, 4'h0, 3'd0);
        got = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid != '0) chk("rstx_stale_rsp", {62'd0, rsp_valid}, 64'd0);
            if (req_ready != '0) begin got = 1; break; end
        end
        chk("rstx_first_grant", {62'd0, got, req_ready[0]}, {62'd0, 1'b1, 1'b1});
        req_valid = '0;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid != '0) begin got = 1; break; end
        end
        chk("rstx_rsp", {30'd0, got, rsp_valid, rsp_rdata}, {30'd0, 1'b1, 2'b01, 32'h12345678});
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // Watchdog: pready never arrives; 16 ACCESS cycles (2..17), response at cycle 18
        cur_wait = 1000; cur_err = 1'b0;
        drive_req(0, 1'b0, 32'd3, 32'h0, 4'h0, 3'd0);
        tick();
        req_valid = '0;
        got = 0;
        begin
            int cy;
            for (cy = 2; cy < 40; cy++) begin
                tick();
                if (rsp_valid != '0) begin got = 1; break; end
            end
            chk("to_latency", 64'(cy), 64'd18);
        end
        chk("to_rsp", {28'd0, got, psel, penable, rsp_err, rsp_rdata}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        chk("to_rsp_valid", {62'd0, rsp_valid}, 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "tb timeout");
    end
endmodule
